// File: rtl/rare_cone_monitor.sv
// rare_cone_monitor
//   Multi-channel activation monitor built from CH copies of a registered NAND/NOR cone.
//   Each channel samples its six inputs through a STAGES-deep flop pipeline, evaluates
//   v = (a & ~(b & c)) & (~(d | e) & f) on the last stage, registers ~v as cone_n, and
//   counts activations in a saturating counter. A small FSM raises a sticky trigger once
//   any channel's count reaches THRESH.
// Ports
//   mon_clk   rising-edge clock
//   mon_rst   asynchronous active-low reset
//   en        enables counting and arming (IDLE -> RUN)
//   clr       synchronous clear of counters, hit, trig_ch and FSM
//   a..f      cone inputs, bit i belongs to channel i
//   cone_n    registered inverted cone value per channel
//   cnt       channel i count at [i*CNT_W +: CNT_W]
//   hit       sticky per-channel "count reached THRESH"
//   trig      high while the FSM is in TRIG
//   trig_ch   lowest channel that caused the trigger
//   state     00 IDLE, 01 RUN, 10 TRIG
module rare_cone_monitor #(
    parameter int unsigned CH     = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 16,
    localparam int unsigned TCW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  mon_clk,
    input  logic                  mon_rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [CH-1:0]         a,
    input  logic [CH-1:0]         b,
    input  logic [CH-1:0]         c,
    input  logic [CH-1:0]         d,
    input  logic [CH-1:0]         e,
    input  logic [CH-1:0]         f,
    output logic [CH-1:0]         cone_n,
    output logic [CH*CNT_W-1:0]   cnt,
    output logic [CH-1:0]         hit,
    output logic                  trig,
    output logic [TCW-1:0]        trig_ch,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StTrig = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

    // Input pipeline: all six signals of every channel travel together, stage 0 first.
    logic [STAGES-1:0][6*CH-1:0] pipe_q;
    logic [6*CH-1:0]             last;
    logic [CH-1:0]               v;

    logic [CH-1:0]               cone_n_q;
    logic [CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH-1:0]               hit_q, hit_d;
    logic [CH-1:0]               new_hit;
    logic [TCW-1:0]              first_ch;
    logic [TCW-1:0]              trig_ch_q, trig_ch_d;
    state_e                      state_q, state_d;
    logic                        count_ok;

    always_ff @(posedge mon_clk or negedge mon_rst) begin
        if (!mon_rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {f, e, d, c, b, a};
            for (int s = 1; s < int'(STAGES); s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign last = pipe_q[STAGES-1];
    assign v    = last[0*CH +: CH] & ~(last[1*CH +: CH] & last[2*CH +: CH])
                & ~(last[3*CH +: CH] | last[4*CH +: CH]) & last[5*CH +: CH];

    // Counting is only live once armed; the IDLE->RUN edge itself never counts.
    assign count_ok = en && ((state_q == StRun) || (state_q == StTrig));

    always_comb begin
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        state_d   = state_q;
        trig_ch_d = trig_ch_q;
        first_ch  = '0;

        for (int i = 0; i < int'(CH); i++) begin
            if (count_ok && v[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (cnt_d[i] >= ThreshVal) begin
                hit_d[i] = 1'b1;
            end
        end

        new_hit = hit_d & ~hit_q;
        // Descending scan so the lowest newly-hit channel wins.
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (new_hit[i]) begin
                first_ch = TCW'(i);
            end
        end

        case (state_q)
            StIdle: begin
                if (en) state_d = StRun;
            end
            StRun: begin
                if (|new_hit) begin
                    state_d   = StTrig;
                    trig_ch_d = first_ch;
                end else if (!en) begin
                    state_d = StIdle;
                end
            end
            StTrig: begin
                state_d = StTrig;
            end
            default: state_d = StIdle;
        endcase

        // Clear drops any same-edge increment, hit or trigger.
        if (clr) begin
            cnt_d     = '0;
            hit_d     = '0;
            trig_ch_d = '0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge mon_clk or negedge mon_rst) begin
        if (!mon_rst) begin
            cone_n_q  <= '0;
            cnt_q     <= '0;
            hit_q     <= '0;
            trig_ch_q <= '0;
            state_q   <= StIdle;
        end else begin
            cone_n_q  <= ~v;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            trig_ch_q <= trig_ch_d;
            state_q   <= state_d;
        end
    end

    assign cone_n  = cone_n_q;
    assign cnt     = cnt_q;
    assign hit     = hit_q;
    assign trig    = (state_q == StTrig);
    assign trig_ch = trig_ch_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rare_cone_monitor.sv
// Directed bench for rare_cone_monitor: main instance with default parameters and a
// second instance (CNT_W=4, THRESH=15) for counter saturation.
module tb_rare_cone_monitor;

    logic        mon_clk = 1'b0;
    logic        mon_rst;
    logic        en, clr;
    logic [3:0]  a, b, c, d, e, f;
    logic [3:0]  cone_n, hit;
    logic [31:0] cnt;
    logic        trig;
    logic [1:0]  trig_ch, state;

    logic        s_en, s_clr;
    logic [3:0]  s_a, s_b, s_c, s_d, s_e, s_f;
    logic [3:0]  s_cone_n, s_hit;
    logic [15:0] s_cnt;
    logic        s_trig;
    logic [1:0]  s_trig_ch, s_state;

    int tests  = 0;
    int errors = 0;

    always #5 mon_clk = ~mon_clk;

    rare_cone_monitor #(.CH(4), .STAGES(2), .CNT_W(8), .THRESH(16)) u_dut (
        .mon_clk (mon_clk), .mon_rst (mon_rst), .en (en), .clr (clr),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f),
        .cone_n (cone_n), .cnt (cnt), .hit (hit), .trig (trig),
        .trig_ch (trig_ch), .state (state)
    );

    rare_cone_monitor #(.CH(4), .STAGES(2), .CNT_W(4), .THRESH(15)) u_sat (
        .mon_clk (mon_clk), .mon_rst (mon_rst), .en (s_en), .clr (s_clr),
        .a (s_a), .b (s_b), .c (s_c), .d (s_d), .e (s_e), .f (s_f),
        .cone_n (s_cone_n), .cnt (s_cnt), .hit (s_hit), .trig (s_trig),
        .trig_ch (s_trig_ch), .state (s_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge mon_clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] va, vb, vc, vd, ve, vf);
        a = va; b = vb; c = vc; d = vd; e = ve; f = vf;
    endtask

    initial begin
        mon_rst = 1'b0; en = 1'b0; clr = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        s_en = 1'b0; s_clr = 1'b0;
        s_a = '0; s_b = '0; s_c = '0; s_d = '0; s_e = '0; s_f = '0;

        // Reset state
        #2;
        check("rst_cone_n", cone_n, 4'h0);
        check("rst_cnt", cnt, 32'h0);
        check("rst_hit", hit, 4'h0);
        check("rst_trig", trig, 1'b0);
        check("rst_trig_ch", trig_ch, 2'd0);
        check("rst_state", state, 2'b00);

        // 1: cone function and 3-edge latency. v = 0011 -> cone_n = 1100
        #10;
        mon_rst = 1'b1;
        set_in(4'b1111, 4'b0110, 4'b0100, 4'b1000, 4'b0000, 4'b1111);
        step(1);
        check("cone_e1_zero_stage", cone_n, 4'b1111);
        step(1);
        check("cone_e2", cone_n, 4'b1111);
        step(1);
        check("cone_v1", cone_n, 4'b1100);
        // v = 1001 (ch1 blocked by e, ch2 by f low)
        set_in(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1011);
        step(2);
        check("cone_v2_hold", cone_n, 4'b1100);
        step(1);
        check("cone_v2", cone_n, 4'b0110);
        // v = 0111 (ch3 a low)
        set_in(4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        step(3);
        check("cone_v3", cone_n, 4'b1000);
        check("idle_no_count", cnt, 32'h0);
        check("idle_state", state, 2'b00);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(3);
        check("cone_zero", cone_n, 4'b1111);

        // 3: saturation on the narrow instance, ch2 active 30 cycles
        s_en = 1'b1; s_a = 4'b0100; s_f = 4'b0100;
        step(16);
        check("sat_cnt14", s_cnt, 16'h0E00);
        check("sat_no_hit", s_hit, 4'h0);
        step(1);
        check("sat_cnt15", s_cnt, 16'h0F00);
        check("sat_hit", s_hit, 4'b0100);
        check("sat_trig", s_trig, 1'b1);
        check("sat_trig_ch", s_trig_ch, 2'd2);
        step(13);
        s_a = '0; s_f = '0; s_en = 1'b0;
        check("sat_no_wrap", s_cnt, 16'h0F00);
        check("sat_hit_sticky", s_hit, 4'b0100);

        // 2: ch1 active 20 cycles, threshold 16
        en = 1'b1;
        set_in(4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010);
        step(1);
        check("arm_run", state, 2'b01);
        step(16);
        check("ch1_cnt15", cnt, 32'h0000_0F00);
        check("ch1_pre_state", state, 2'b01);
        check("ch1_pre_hit", hit, 4'h0);
        step(1);
        check("ch1_cnt16", cnt, 32'h0000_1000);
        check("ch1_hit", hit, 4'b0010);
        check("ch1_trig", trig, 1'b1);
        check("ch1_state", state, 2'b10);
        check("ch1_trig_ch", trig_ch, 2'd1);
        step(2);
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(2);
        check("ch1_cnt20", cnt, 32'h0000_1400);
        step(3);
        check("ch1_cnt20_hold", cnt, 32'h0000_1400);
        en = 1'b0;
        step(2);
        check("trig_sticky_en0", state, 2'b10);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_cnt", cnt, 32'h0);
        check("clr_hit", hit, 4'h0);
        check("clr_state", state, 2'b00);
        check("clr_trig_ch", trig_ch, 2'd0);
        check("clr_cone_n_kept", cone_n, 4'b1111);

        // 4: ch0 and ch3 reach threshold together
        en = 1'b1;
        set_in(4'b1001, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1001);
        step(18);
        check("dual_hit", hit, 4'b1001);
        check("dual_trig_ch", trig_ch, 2'd0);
        check("dual_state", state, 2'b10);
        en = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(2);
        check("dual_sticky", state, 2'b10);
        check("dual_cnt_hold", cnt, 32'h1000_0010);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(2);

        // 5: clr on the threshold edge drops the trigger
        en = 1'b1;
        set_in(4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010);
        step(17);
        check("c5_cnt15", cnt, 32'h0000_0F00);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        en = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        check("c5_cnt", cnt, 32'h0);
        check("c5_hit", hit, 4'h0);
        check("c5_trig", trig, 1'b0);
        check("c5_state", state, 2'b00);
        step(3);
        check("c5_still_idle", state, 2'b00);

        // 6: asynchronous reset mid-count
        en = 1'b1;
        set_in(4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001);
        step(9);
        check("r6_cnt7", cnt, 32'h0000_0007);
        #3;
        mon_rst = 1'b0;
        #1;
        check("r6_async_cnt", cnt, 32'h0);
        check("r6_async_state", state, 2'b00);
        check("r6_async_cone_n", cone_n, 4'h0);
        #2;
        mon_rst = 1'b1;
        #1;
        check("r6_rel_idle", state, 2'b00);
        step(1);
        check("r6_run", state, 2'b01);
        check("r6_cnt0_a", cnt, 32'h0);
        step(1);
        check("r6_cnt0_b", cnt, 32'h0);
        step(1);
        check("r6_cnt1", cnt, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
